// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style PIC interrupt core:
// INTA FSM states, OCW2 command codes, strobe bit indices and the priority-rank helper.
package pic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK1,
        ST_GAP,
        ST_ACK2
    } inta_state_t;

    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_S_EOI        = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
    localparam logic [2:0] OCW2_ROT_S_EOI    = 3'b111;

    // Bit positions inside icw_stb / ocw_stb (ICW1..ICW4, OCW1..OCW3)
    localparam int ICW1 = 0;
    localparam int ICW2 = 1;
    localparam int ICW3 = 2;
    localparam int ICW4 = 3;
    localparam int OCW1 = 0;
    localparam int OCW2 = 1;
    localparam int OCW3 = 2;

    // Rank 0 is the highest priority level (lp+1), rank 7 is lp itself.
    function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lp);
        return lvl - lp - 3'd1;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational rotating-priority encoder: scans from lp+1 (highest) around to lp (lowest)
// and reports whether any request is set and which level wins.
module pic_priority_resolver (
    input  logic [7:0] req,
    input  logic [2:0] lp,
    output logic       vld,
    output logic [2:0] win
);

    logic [2:0] idx;

    always_comb begin
        vld = 1'b0;
        win = 3'd7;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            idx = lp + 3'd1 + i[2:0];
            if (!vld && req[idx]) begin
                vld = 1'b1;
                win = idx;
            end
        end
    end

endmodule

// File: rtl/pic_int_sequencer.sv
// 8259-style interrupt core: IRR/ISR/IMR, fully nested priority, INTA two-pulse handshake.
// Define PIC_ROTATE_EN to enable the OCW2 rotation / set-priority / rotate-in-AEOI commands.
module pic_int_sequencer
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir,
    input  logic       inta_n,
    input  logic [3:0] icw_stb,
    input  logic [2:0] ocw_stb,
    input  logic [7:0] wdata,
    output logic       int_out,
    output logic [7:0] vec_out,
    output logic       vec_oe,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic [7:0] imr,
    output logic       rd_isr
);

    inta_state_t state;
    logic [7:0]  ir_p0, ir_p1, ir_p2;
    logic        ltim, aeoi;
    logic [4:0]  base;
    logic [2:0]  lp, lp_next, win;
    logic [7:0]  irr_next, isr_next, ack_mask, eoi_mask;
    logic        cand_vld, isr_vld, int_req, ack_evt, aeoi_evt;
    logic [2:0]  cand_win, isr_win;
    logic        icw3_unused;
`ifdef PIC_ROTATE_EN
    logic        rot_aeoi, rot_aeoi_next;
`endif

    assign icw3_unused = icw_stb[ICW3];

    pic_priority_resolver u_cand_res (
        .req (irr & ~imr),
        .lp  (lp),
        .vld (cand_vld),
        .win (cand_win)
    );

    pic_priority_resolver u_isr_res (
        .req (isr),
        .lp  (lp),
        .vld (isr_vld),
        .win (isr_win)
    );

    assign int_req  = cand_vld && (!isr_vld || (prio_rank(cand_win, lp) < prio_rank(isr_win, lp)));
    assign ack_evt  = (state == ST_IDLE) && !inta_n;
    assign aeoi_evt = (state == ST_ACK2) && inta_n && aeoi;

    always_comb begin
        ack_mask = '0;
        eoi_mask = '0;
        lp_next  = lp;
`ifdef PIC_ROTATE_EN
        rot_aeoi_next = rot_aeoi;
`endif
        if (ack_evt && cand_vld)
            ack_mask[cand_win] = 1'b1;
        if (ocw_stb[OCW2]) begin
            case (wdata[7:5])
                OCW2_NS_EOI: if (isr_vld) eoi_mask[isr_win] = 1'b1;
                OCW2_S_EOI:  eoi_mask[wdata[2:0]] = 1'b1;
`ifdef PIC_ROTATE_EN
                OCW2_ROT_NS_EOI: if (isr_vld) begin
                    eoi_mask[isr_win] = 1'b1;
                    lp_next = isr_win;
                end
                OCW2_ROT_S_EOI: begin
                    eoi_mask[wdata[2:0]] = 1'b1;
                    lp_next = wdata[2:0];
                end
                OCW2_SET_PRI:      lp_next = wdata[2:0];
                OCW2_ROT_AEOI_SET: rot_aeoi_next = 1'b1;
                OCW2_ROT_AEOI_CLR: rot_aeoi_next = 1'b0;
`else
                OCW2_ROT_NS_EOI: if (isr_vld) eoi_mask[isr_win] = 1'b1;
                OCW2_ROT_S_EOI:  eoi_mask[wdata[2:0]] = 1'b1;
`endif
                default: ;
            endcase
        end
        if (aeoi_evt) begin
            eoi_mask[win] = 1'b1;
`ifdef PIC_ROTATE_EN
            if (rot_aeoi)
                lp_next = win;
`endif
        end
        isr_next = (isr & ~eoi_mask) | ack_mask;
        irr_next = ltim ? (ir_p1 & ~ack_mask) : ((irr & ~ack_mask) | (ir_p1 & ~ir_p2));
    end

    // Register file: synchronizer (p0/p1) plus previous synced value (p2) for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_p0  <= '0;
            ir_p1  <= '0;
            ir_p2  <= '0;
            irr    <= '0;
            isr    <= '0;
            imr    <= 8'hFF;
            ltim   <= 1'b0;
            aeoi   <= 1'b0;
            base   <= '0;
            lp     <= 3'd7;
            rd_isr <= 1'b0;
`ifdef PIC_ROTATE_EN
            rot_aeoi <= 1'b0;
`endif
        end else begin
            ir_p0 <= ir;
            ir_p1 <= ir_p0;
            ir_p2 <= ir_p1;
            if (icw_stb[ICW1]) begin
                irr    <= '0;
                isr    <= '0;
                imr    <= '0;
                ltim   <= wdata[3];
                aeoi   <= 1'b0;
                rd_isr <= 1'b0;
                lp     <= 3'd7;
            end else begin
                irr <= irr_next;
                isr <= isr_next;
                lp  <= lp_next;
`ifdef PIC_ROTATE_EN
                rot_aeoi <= rot_aeoi_next;
`endif
                if (icw_stb[ICW2]) base <= wdata[7:3];
                if (icw_stb[ICW4]) aeoi <= wdata[1];
                if (ocw_stb[OCW1]) imr  <= wdata;
                if (ocw_stb[OCW3] && wdata[1]) rd_isr <= wdata[0];
            end
        end
    end

    // INTA handshake; int_out is held low whenever the FSM is not (returning to) IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            win     <= 3'd7;
            int_out <= 1'b0;
            vec_out <= '0;
            vec_oe  <= 1'b0;
        end else if (icw_stb[ICW1]) begin
            state   <= ST_IDLE;
            int_out <= 1'b0;
            vec_oe  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!inta_n) begin
                        state   <= ST_ACK1;
                        win     <= cand_vld ? cand_win : 3'd7;
                        int_out <= 1'b0;
                    end else begin
                        int_out <= int_req;
                    end
                end
                ST_ACK1: begin
                    int_out <= 1'b0;
                    if (inta_n) state <= ST_GAP;
                end
                ST_GAP: begin
                    int_out <= 1'b0;
                    if (!inta_n) begin
                        state   <= ST_ACK2;
                        vec_out <= {base, win};
                        vec_oe  <= 1'b1;
                    end
                end
                ST_ACK2: begin
                    if (inta_n) begin
                        state   <= ST_IDLE;
                        vec_oe  <= 1'b0;
                        int_out <= int_req;
                    end else begin
                        int_out <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
